// File: rtl/mm_pe_scheduler.sv
// Schedules N*N dot products on one PE to form C = A x B from row/column memory fetches.
// Optional build macro MM_PE_SCHED_ERR_ABORT_EN: a PE error ends the operation at once, skipping that write.
module mm_pe_scheduler #(
   parameter int N           = 8,
   parameter int DATA_WIDTH  = 16,
   parameter int ACCUM_WIDTH = 2*DATA_WIDTH,
   parameter int PE_LAT      = N+2,
   parameter int ADDR_W      = $clog2(N*N)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic                     a_rd_en,
   output logic [ADDR_W-1:0]        a_rd_addr,
   input  logic [DATA_WIDTH-1:0]    a_rd_data,
   output logic                     b_rd_en,
   output logic [ADDR_W-1:0]        b_rd_addr,
   input  logic [DATA_WIDTH-1:0]    b_rd_data,
   output logic                     pe_init,
   output logic [N*DATA_WIDTH-1:0]  pe_row,
   output logic [N*DATA_WIDTH-1:0]  pe_col,
   input  logic [ACCUM_WIDTH-1:0]   pe_total,
   input  logic                     pe_err,
   output logic                     c_wr_en,
   output logic [ADDR_W-1:0]        c_wr_addr,
   output logic [ACCUM_WIDTH-1:0]   c_wr_data
);

   localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
   localparam int K_W    = $clog2(N+1);
   localparam int WAIT_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N-1);
   localparam logic [K_W-1:0]    K_LAST    = K_W'(N);
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(PE_LAT-1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_FIRE,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          i_q, i_d;
   logic [IDX_W-1:0]          j_q, j_d;
   logic [K_W-1:0]            k_q, k_d;
   logic [WAIT_W-1:0]         wait_q, wait_d;
   logic [N*DATA_WIDTH-1:0]   row_q, row_d;
   logic [N*DATA_WIDTH-1:0]   col_q, col_d;
   logic [ACCUM_WIDTH-1:0]    total_q, total_d;
   logic                      err_q, err_d;

   logic [ADDR_W-1:0]         i_ext, j_ext, k_ext, n_ext;
   logic [K_W-1:0]            slot;

   assign i_ext = ADDR_W'(i_q);
   assign j_ext = ADDR_W'(j_q);
   assign k_ext = ADDR_W'(k_q);
   assign n_ext = ADDR_W'(N);

   assign pe_row = row_q;
   assign pe_col = col_q;
   assign err    = err_q;

   // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      k_d       = k_q;
      wait_d    = wait_q;
      row_d     = row_q;
      col_d     = col_q;
      total_d   = total_q;
      err_d     = err_q;
      slot      = k_q - 1'b1;
      busy      = (state_q != S_IDLE);
      done      = 1'b0;
      a_rd_en   = 1'b0;
      b_rd_en   = 1'b0;
      a_rd_addr = '0;
      b_rd_addr = '0;
      pe_init   = 1'b0;
      c_wr_en   = 1'b0;
      c_wr_addr = '0;
      c_wr_data = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               err_d   = 1'b0;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               state_d = S_FETCH;
            end
         end

         S_FETCH: begin
            // Reads issue on cycles 0..N-1; data lands one cycle later in slot k-1.
            if (k_q != K_LAST) begin
               a_rd_en   = 1'b1;
               b_rd_en   = 1'b1;
               a_rd_addr = i_ext * n_ext + k_ext;
               b_rd_addr = k_ext * n_ext + j_ext;
            end
            if (k_q != '0) begin
               row_d[slot*DATA_WIDTH +: DATA_WIDTH] = a_rd_data;
               col_d[slot*DATA_WIDTH +: DATA_WIDTH] = b_rd_data;
            end
            if (k_q == K_LAST) begin
               k_d     = '0;
               state_d = S_FIRE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end

         S_FIRE: begin
            pe_init = 1'b1;
            wait_d  = WAIT_INIT;
            state_d = S_WAIT;
         end

         S_WAIT: begin
            if (wait_q == '0) begin
               total_d = pe_total;
               if (pe_err) begin
                  err_d = 1'b1;
               end
`ifdef MM_PE_SCHED_ERR_ABORT_EN
               state_d = pe_err ? S_DONE : S_WRITE;
`else
               state_d = S_WRITE;
`endif
            end else begin
               wait_d = wait_q - 1'b1;
            end
         end

         S_WRITE: begin
            c_wr_en   = 1'b1;
            c_wr_addr = i_ext * n_ext + j_ext;
            c_wr_data = total_q;
            if (j_q != LAST_IDX) begin
               j_d     = j_q + 1'b1;
               state_d = S_FETCH;
            end else begin
               j_d = '0;
               if (i_q != LAST_IDX) begin
                  i_d     = i_q + 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_DONE;
               end
            end
         end

         S_DONE: begin
            done    = 1'b1;
            busy    = 1'b0;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         wait_q  <= '0;
         // NOTE: the operand buffers are cleared too, because they drive pe_row/pe_col directly.
         row_q   <= '0;
         col_q   <= '0;
         total_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         wait_q  <= wait_d;
         row_q   <= row_d;
         col_q   <= col_d;
         total_q <= total_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_mm_pe_scheduler.sv
// Directed bench for mm_pe_scheduler at N=2: memory and PE models, protocol monitor, hand-computed C values.
module tb_mm_pe_scheduler;

   localparam int N      = 2;
   localparam int DW     = 16;
   localparam int AW     = 32;
   localparam int PL     = 4;
   localparam int ADDR_W = 2;
   localparam logic [AW-1:0] JUNK = 32'hDEAD_BEEF;

`ifdef MM_PE_SCHED_ERR_ABORT_EN
   localparam bit ABORT = 1'b1;
`else
   localparam bit ABORT = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic              start;
   logic              busy, done, err;
   logic              a_rd_en, b_rd_en;
   logic [ADDR_W-1:0] a_rd_addr, b_rd_addr;
   logic [DW-1:0]     a_rd_data, b_rd_data;
   logic              pe_init;
   logic [N*DW-1:0]   pe_row, pe_col;
   logic [AW-1:0]     pe_total;
   logic              pe_err;
   logic              c_wr_en;
   logic [ADDR_W-1:0] c_wr_addr;
   logic [AW-1:0]     c_wr_data;

   mm_pe_scheduler #(
      .N(N), .DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .PE_LAT(PL), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
      .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
      .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
      .pe_init(pe_init), .pe_row(pe_row), .pe_col(pe_col),
      .pe_total(pe_total), .pe_err(pe_err),
      .c_wr_en(c_wr_en), .c_wr_addr(c_wr_addr), .c_wr_data(c_wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Matrix memories: one-cycle read latency.
   logic [DW-1:0] mem_a [0:N*N-1];
   logic [DW-1:0] mem_b [0:N*N-1];

   always @(posedge clk) begin
      if (a_rd_en) a_rd_data <= mem_a[a_rd_addr];
      if (b_rd_en) b_rd_data <= mem_b[b_rd_addr];
   end

   // PE model: total becomes valid exactly PL cycles after the init cycle, junk before that.
   int            err_at = -1;
   int            pe_cnt = 0;
   int            pcnt   = 0;
   logic [AW-1:0] pend;
   logic          perr_p;

   function automatic logic [AW-1:0] dot(input logic [N*DW-1:0] r, input logic [N*DW-1:0] c);
      logic signed [AW-1:0] s;
      s = '0;
      for (int k = 0; k < N; k++) begin
         s += $signed(r[k*DW +: DW]) * $signed(c[k*DW +: DW]);
      end
      return s;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         pcnt     <= 0;
         pe_total <= JUNK;
         pe_err   <= 1'b0;
      end else if (pe_init) begin
         pend     <= dot(pe_row, pe_col);
         perr_p   <= (pe_cnt == err_at);
         pe_cnt   <= pe_cnt + 1;
         pcnt     <= PL - 1;
         pe_total <= JUNK;
         pe_err   <= 1'b0;
      end else if (pcnt == 1) begin
         pe_total <= pend;
         pe_err   <= perr_p;
         pcnt     <= 0;
      end else if (pcnt > 1) begin
         pcnt <= pcnt - 1;
      end
   end

   // Protocol monitor, sampled on the falling edge.
   int            cyc = 0, n_rd = 0, n_init = 0, n_wr = 0, n_done = 0, viol = 0;
   int            done_cyc = 0, post = 0;
   logic          done_err = 1'b0, done_busy = 1'b0, err_p1 = 1'b0, err_p2 = 1'b0;
   bit            hold = 1'b0;
   logic [N*DW-1:0] row_snap, col_snap;
   int            wr_addr [0:255];
   logic [AW-1:0] wr_data [0:255];

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            hold = 1'b0;
            post = 0;
         end else begin
            if (a_rd_en) n_rd++;
            if (a_rd_en !== b_rd_en) viol++;
            if ((a_rd_en || pe_init || c_wr_en) && !busy) viol++;
            if (a_rd_en && (pe_init || c_wr_en)) viol++;
            if (pe_init) begin
               n_init++;
               row_snap = pe_row;
               col_snap = pe_col;
               hold     = 1'b1;
            end else if (hold && (pe_row !== row_snap || pe_col !== col_snap)) begin
               viol++;
            end
            if (c_wr_en && n_wr < 256) begin
               wr_addr[n_wr] = int'(c_wr_addr);
               wr_data[n_wr] = c_wr_data;
               n_wr++;
               hold = 1'b0;
            end
            if (post == 1) begin
               err_p1 = err;
               post   = 2;
            end else if (post == 2) begin
               err_p2 = err;
               post   = 0;
            end
            if (done) begin
               n_done++;
               done_cyc  = cyc;
               done_err  = err;
               done_busy = busy;
               hold      = 1'b0;
               post      = 1;
            end
         end
      end
   end

   int n_cmp = 0;
   int n_bad = 0;
   int acc_cyc = 0, b_wr = 0, b_init = 0, b_rd = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                tag, $signed(obs), obs, $signed(exp), exp);
      end
   endtask

   task automatic load(input int a0, a1, a2, a3, input int b0, b1, b2, b3);
      mem_a[0] = DW'(a0); mem_a[1] = DW'(a1); mem_a[2] = DW'(a2); mem_a[3] = DW'(a3);
      mem_b[0] = DW'(b0); mem_b[1] = DW'(b1); mem_b[2] = DW'(b2); mem_b[3] = DW'(b3);
   endtask

   task automatic start_op(input bit keep_start);
      b_wr   = n_wr;
      b_init = n_init;
      b_rd   = n_rd;
      @(posedge clk); #1 start = 1'b1;
      @(negedge clk); #1 acc_cyc = cyc;
      @(posedge clk); #1 if (!keep_start) start = 1'b0;
   endtask

   task automatic wait_done(input string t);
      int  base;
      bit  got;
      base = n_done;
      got  = 1'b0;
      for (int x = 0; x < 300; x++) begin
         @(posedge clk); #1;
         if (n_done != base) begin
            got = 1'b1;
            break;
         end
      end
      check({t, "_done_seen"}, 32'(got), 32'd1);
   endtask

   task automatic check_op(input string t, input int exp_wr, input int exp_init,
                           input int c0, c1, c2, c3, input int exp_lat, input logic exp_err);
      int c [0:3];
      c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
      check({t, "_nwr"}, 32'(n_wr - b_wr), 32'(exp_wr));
      for (int x = 0; x < exp_wr; x++) begin
         check($sformatf("%s_addr%0d", t, x), 32'(wr_addr[b_wr + x]), 32'(x));
         check($sformatf("%s_data%0d", t, x), wr_data[b_wr + x], 32'(c[x]));
      end
      check({t, "_latency"}, 32'(done_cyc - acc_cyc), 32'(exp_lat));
      check({t, "_err"}, 32'(done_err), 32'(exp_err));
      check({t, "_busy_at_done"}, 32'(done_busy), 32'd0);
      check({t, "_ninit"}, 32'(n_init - b_init), 32'(exp_init));
      check({t, "_nrd"}, 32'(n_rd - b_rd), 32'(exp_init * N));
      check({t, "_protocol"}, 32'(viol), 32'd0);
   endtask

   task automatic check_quiet(input string t);
      check({t, "_ctl"}, 32'({busy, done, err, a_rd_en, b_rd_en, pe_init, c_wr_en}), 32'd0);
      check({t, "_addr"}, 32'({a_rd_addr, b_rd_addr, c_wr_addr}), 32'd0);
      check({t, "_row"}, pe_row, 32'd0);
      check({t, "_col"}, pe_col, 32'd0);
      check({t, "_cdata"}, c_wr_data, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd_snap;

      rst   = 1'b1;
      start = 1'b0;
      load(1, 2, 3, 4, 5, 6, 7, 8);
      repeat (3) @(posedge clk);
      #1 check_quiet("reset");
      rst = 1'b0;

      // Basic product.
      start_op(1'b0);
      wait_done("t1");
      check_op("t1", 4, 4, 19, 22, 43, 50, 37, 1'b0);

      // Signed operands.
      load(-1, 2, 3, -4, 5, -6, 7, 8);
      start_op(1'b0);
      wait_done("t2");
      check_op("t2", 4, 4, 9, 22, -13, -50, 37, 1'b0);

      // Reset during the second element's WAIT.
      load(1, 2, 3, 4, 5, 6, 7, 8);
      start_op(1'b0);
      for (int x = 0; x < 100; x++) begin
         if (n_init - b_init >= 2) break;
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      check_quiet("t3_rst");
      check("t3_wr_before_rst", 32'(n_wr - b_wr), 32'd1);
      rst     = 1'b0;
      rd_snap = n_rd;
      repeat (5) @(posedge clk);
      #1;
      check("t3_no_reads_after_rst", 32'(n_rd - rd_snap), 32'd0);
      check("t3_no_writes_after_rst", 32'(n_wr - b_wr), 32'd1);
      check("t3_busy_after_rst", 32'(busy), 32'd0);
      start_op(1'b0);
      wait_done("t3b");
      check_op("t3b", 4, 4, 19, 22, 43, 50, 37, 1'b0);

      // PE error on element (0,1).
      err_at = pe_cnt + 1;
      start_op(1'b0);
      wait_done("t4");
      if (ABORT) check_op("t4", 1, 2, 19, 0, 0, 0, 18, 1'b1);
      else       check_op("t4", 4, 4, 19, 22, 43, 50, 37, 1'b1);

      // Start pulsed while busy, then held high through DONE.
      err_at = pe_cnt + 1;
      start_op(1'b0);
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (7) @(posedge clk);
      #1 start = 1'b1;
      wait_done("t5a");
      if (ABORT) check_op("t5a", 1, 2, 19, 0, 0, 0, 18, 1'b1);
      else       check_op("t5a", 4, 4, 19, 22, 43, 50, 37, 1'b1);
      acc_cyc = done_cyc + 1;
      b_wr    = n_wr;
      b_init  = n_init;
      b_rd    = n_rd;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk); #1;
      check("t5_err_in_idle", 32'(err_p1), 32'd1);
      check("t5_err_after_accept", 32'(err_p2), 32'd0);
      wait_done("t5b");
      check_op("t5b", 4, 4, 19, 22, 43, 50, 37, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
